// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core constants, LSU error codes and helpers
package core_pkg;

    localparam int DATA_MEM_DEPTH = 1024;
    localparam int LSU_MAX_READ_LATENCY = 4;

    localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;

    localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
    localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
    localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;

    typedef enum logic [1:0] {
        LSU_OK         = 2'd0,
        LSU_MISALIGNED = 2'd1,
        LSU_ILLEGAL    = 2'd2,
        LSU_RSVD       = 2'd3
    } lsu_err_e;

    // Classify a request at acceptance; an illegal funct3 outranks misalignment
    function automatic lsu_err_e lsu_check(input logic we, input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = (funct3 > 3'd2);
        end else begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        if (illegal) begin
            return LSU_ILLEGAL;
        end else if (misaligned) begin
            return LSU_MISALIGNED;
        end
        return LSU_OK;
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and lane extraction/extension for loads
module dmem_lane_align
    import core_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate right-aligned data across lanes and enable only the addressed ones
    always_comb begin
        st_be   = 4'b0000;
        st_data = '0;
        case (st_funct3)
            FUNCT3_STORE_SB: begin
                st_be   = 4'b0001 << st_addr;
                st_data = {4{st_wdata[7:0]}};
            end
            FUNCT3_STORE_SH: begin
                st_be   = st_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{st_wdata[15:0]}};
            end
            FUNCT3_STORE_SW: begin
                st_be   = 4'b1111;
                st_data = st_wdata;
            end
            default: ;
        endcase
    end

    // Load: pick the addressed byte/half out of the raw word and extend it
    always_comb begin
        ld_byte = ld_word[{ld_addr, 3'b000} +: 8];
        ld_half = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = '0;
        case (ld_funct3)
            FUNCT3_LOAD_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            FUNCT3_LOAD_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            FUNCT3_LOAD_LW:  ld_data = ld_word;
            FUNCT3_LOAD_LBU: ld_data = {24'd0, ld_byte};
            FUNCT3_LOAD_LHU: ld_data = {16'd0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_pipe.sv
// rtl/dmem_lsu_pipe.sv - pipelined data memory and load/store unit; DMEM_LSU_STATS_EN adds counters
module dmem_lsu_pipe
    import core_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = DATA_MEM_DEPTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [1:0]            resp_err_o,
    output logic                  resp_is_store_o
`ifdef DMEM_LSU_STATS_EN
    ,
    output logic [31:0]           stat_loads_o,
    output logic [31:0]           stat_stores_o,
    output logic [31:0]           stat_errs_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OUT   = READ_LATENCY - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [READ_LATENCY-1:0] st_valid;
    logic                    st_we     [READ_LATENCY];
    logic [2:0]              st_funct3 [READ_LATENCY];
    logic [1:0]              st_addr   [READ_LATENCY];
    lsu_err_e                st_err    [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   st_word   [READ_LATENCY];

    logic                  stall;
    logic                  accept;
    logic                  wr_en;
    logic [IDX_W-1:0]      idx;
    lsu_err_e              req_err;
    logic [3:0]            wr_be;
    logic [DATA_WIDTH-1:0] wr_lane_data;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  unused_addr_bits;

    assign resp_valid_o     = st_valid[OUT];
    assign stall            = resp_valid_o && !resp_ready_i;
    assign req_ready_o      = !rst && !stall;
    assign accept           = req_valid_i && req_ready_o;
    assign idx              = req_addr_i[IDX_W+1:2];
    assign req_err          = lsu_check(req_we_i, req_funct3_i, req_addr_i[1:0]);
    assign wr_en            = accept && req_we_i && (req_err == LSU_OK);
    assign unused_addr_bits = ^req_addr_i[31:IDX_W+2];

    dmem_lane_align u_align (
        .st_funct3 (req_funct3_i),
        .st_addr   (req_addr_i[1:0]),
        .st_wdata  (req_wdata_i),
        .st_be     (wr_be),
        .st_data   (wr_lane_data),
        .ld_funct3 (st_funct3[OUT]),
        .ld_addr   (st_addr[OUT]),
        .ld_word   (st_word[OUT]),
        .ld_data   (ld_data)
    );

    // Byte-masked write on the acceptance edge; raw word read on the same edge and carried down the pipe
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_lane_data[8*b +: 8];
                end
            end
        end
        if (!stall) begin
            st_word[0] <= mem[idx];
            for (int k = 1; k < READ_LATENCY; k++) begin
                st_word[k] <= st_word[k-1];
            end
        end
    end

    // Control stages advance together unless the output stage is blocked by the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                st_we[k]     <= 1'b0;
                st_funct3[k] <= '0;
                st_addr[k]   <= '0;
                st_err[k]    <= LSU_OK;
            end
        end else if (!stall) begin
            st_valid[0]  <= accept;
            st_we[0]     <= req_we_i;
            st_funct3[0] <= req_funct3_i;
            st_addr[0]   <= req_addr_i[1:0];
            st_err[0]    <= req_err;
            for (int k = 1; k < READ_LATENCY; k++) begin
                st_valid[k]  <= st_valid[k-1];
                st_we[k]     <= st_we[k-1];
                st_funct3[k] <= st_funct3[k-1];
                st_addr[k]   <= st_addr[k-1];
                st_err[k]    <= st_err[k-1];
            end
        end
    end

    // Response fields are forced quiet unless the output stage holds a valid entry
    always_comb begin
        resp_rdata_o    = '0;
        resp_err_o      = LSU_OK;
        resp_is_store_o = 1'b0;
        if (resp_valid_o) begin
            resp_err_o      = st_err[OUT];
            resp_is_store_o = st_we[OUT];
            if (!st_we[OUT] && (st_err[OUT] == LSU_OK)) begin
                resp_rdata_o = ld_data;
            end
        end
    end

`ifdef DMEM_LSU_STATS_EN
    logic resp_hs;
    assign resp_hs = resp_valid_o && resp_ready_i;

    // Errored responses count only as errors; clean ones by direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads_o  <= '0;
            stat_stores_o <= '0;
            stat_errs_o   <= '0;
        end else if (resp_hs) begin
            if (st_err[OUT] != LSU_OK) begin
                stat_errs_o <= sat_inc(stat_errs_o);
            end else if (st_we[OUT]) begin
                stat_stores_o <= sat_inc(stat_stores_o);
            end else begin
                stat_loads_o <= sat_inc(stat_loads_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_lsu_pipe.sv
// tb/tb_dmem_lsu_pipe.sv - directed self-checking bench for dmem_lsu_pipe
module tb_dmem_lsu_pipe;
    import core_pkg::*;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        resp_is_store;
`ifdef DMEM_LSU_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;
`endif

    int checks = 0;
    int errors = 0;

    logic        s_we    [8];
    logic [2:0]  s_f3    [8];
    logic [31:0] s_addr  [8];
    logic [31:0] s_wdata [8];
    logic [31:0] s_exp   [8];

    always #5 clk = ~clk;

    dmem_lsu_pipe #(.DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(L)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_we_i        (req_we),
        .req_funct3_i    (req_funct3),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_rdata_o    (resp_rdata),
        .resp_err_o      (resp_err),
        .resp_is_store_o (resp_is_store)
`ifdef DMEM_LSU_STATS_EN
        ,
        .stat_loads_o    (stat_loads),
        .stat_stores_o   (stat_stores),
        .stat_errs_o     (stat_errs)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One isolated request: check ready, latency and the response fields
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        int n;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, L - 1);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {30'd0, resp_err}, {30'd0, exp_err});
        check({tag, "_is_store"}, {31'd0, resp_is_store}, {31'd0, we});
        @(posedge clk); #1;
    endtask

    // Back-to-back requests from the s_* table, with resp_ready dropped for a window of cycles
    task automatic run_stream(input string tag, input int n, input int stall_from, input int stall_len);
        int sent;
        int got;
        int cyc;
        logic acc;
        sent = 0; got = 0; cyc = 0;
        while (got < n && cyc < 60) begin
            resp_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            if (sent < n) begin
                req_valid = 1'b1; req_we = s_we[sent]; req_funct3 = s_f3[sent];
                req_addr = s_addr[sent]; req_wdata = s_wdata[sent];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (cyc >= stall_from && cyc < stall_from + stall_len) begin
                check($sformatf("%s_stall_ready_c%0d", tag, cyc), {31'd0, req_ready}, 32'd0);
            end
            acc = req_valid && req_ready;
            if (resp_valid && resp_ready) begin
                check($sformatf("%s_rsp%0d", tag, got), resp_rdata, s_exp[got]);
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {30'd0, resp_err}, 32'd0);
        check("rst_is_store", {31'd0, resp_is_store}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        txn("sw10", 1'b1, FUNCT3_STORE_SW, 32'h10, 32'hDEADBEEF, 32'h0, LSU_OK);
        txn("lw10", 1'b0, FUNCT3_LOAD_LW, 32'h10, 32'h0, 32'hDEADBEEF, LSU_OK);
        txn("lb13", 1'b0, FUNCT3_LOAD_LB, 32'h13, 32'h0, 32'hFFFFFFDE, LSU_OK);
        txn("lbu13", 1'b0, FUNCT3_LOAD_LBU, 32'h13, 32'h0, 32'h000000DE, LSU_OK);
        txn("lh12", 1'b0, FUNCT3_LOAD_LH, 32'h12, 32'h0, 32'hFFFFDEAD, LSU_OK);
        txn("lhu10", 1'b0, FUNCT3_LOAD_LHU, 32'h10, 32'h0, 32'h0000BEEF, LSU_OK);
        txn("sb11", 1'b1, FUNCT3_STORE_SB, 32'h11, 32'h55, 32'h0, LSU_OK);
        txn("lw10_sb", 1'b0, FUNCT3_LOAD_LW, 32'h10, 32'h0, 32'hDEAD55EF, LSU_OK);
        txn("lw12_mis", 1'b0, FUNCT3_LOAD_LW, 32'h12, 32'h0, 32'h0, LSU_MISALIGNED);
        txn("st_f3_ill", 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 32'h0, LSU_ILLEGAL);
        txn("sh11_mis", 1'b1, FUNCT3_STORE_SH, 32'h11, 32'h7777, 32'h0, LSU_MISALIGNED);
        txn("lw10_kept", 1'b0, FUNCT3_LOAD_LW, 32'h10, 32'h0, 32'hDEAD55EF, LSU_OK);
        txn("ld_f7_ill", 1'b0, 3'd7, 32'h11, 32'h0, 32'h0, LSU_ILLEGAL);
        txn("sw1000", 1'b1, FUNCT3_STORE_SW, 32'h1000, 32'h12345678, 32'h0, LSU_OK);
        txn("lw0_wrap", 1'b0, FUNCT3_LOAD_LW, 32'h0, 32'h0, 32'h12345678, LSU_OK);

        for (int i = 0; i < 6; i++) begin
            s_we[i] = 1'b1; s_f3[i] = FUNCT3_STORE_SW; s_addr[i] = 32'h40 + 32'(4 * i);
            s_wdata[i] = 32'hA000_0000 + 32'(i * 17); s_exp[i] = 32'h0;
        end
        run_stream("fill", 6, 0, 0);
        for (int i = 0; i < 6; i++) begin
            s_we[i] = 1'b0; s_f3[i] = FUNCT3_LOAD_LW; s_addr[i] = 32'h40 + 32'(4 * i);
            s_wdata[i] = 32'h0; s_exp[i] = 32'hA000_0000 + 32'(i * 17);
        end
        run_stream("bp", 6, 4, 4);

        s_we[0] = 1'b1; s_f3[0] = FUNCT3_STORE_SW; s_addr[0] = 32'h60; s_wdata[0] = 32'hCAFEF00D; s_exp[0] = 32'h0;
        s_we[1] = 1'b0; s_f3[1] = FUNCT3_LOAD_LW;  s_addr[1] = 32'h60; s_wdata[1] = 32'h0;       s_exp[1] = 32'hCAFEF00D;
        run_stream("raw", 2, 99, 0);

        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = FUNCT3_LOAD_LW; req_addr = 32'h10;
        @(posedge clk); #1;
        req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstmid_pre_valid", {31'd0, resp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_valid", {31'd0, resp_valid}, 32'd0);
        check("rstmid_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("rstmid_stale", seen, 0);
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);

`ifdef DMEM_LSU_STATS_EN
        txn("st_lw10", 1'b0, FUNCT3_LOAD_LW, 32'h10, 32'h0, 32'hDEAD55EF, LSU_OK);
        txn("st_sw70", 1'b1, FUNCT3_STORE_SW, 32'h70, 32'h1, 32'h0, LSU_OK);
        txn("st_lw0", 1'b0, FUNCT3_LOAD_LW, 32'h0, 32'h0, 32'h12345678, LSU_OK);
        txn("st_sb74", 1'b1, FUNCT3_STORE_SB, 32'h74, 32'h2, 32'h0, LSU_OK);
        txn("st_lbu13", 1'b0, FUNCT3_LOAD_LBU, 32'h13, 32'h0, 32'h000000DE, LSU_OK);
        txn("st_lwmis", 1'b0, FUNCT3_LOAD_LW, 32'h12, 32'h0, 32'h0, LSU_MISALIGNED);
        check("stat_loads", stat_loads, 32'd3);
        check("stat_stores", stat_stores, 32'd2);
        check("stat_errs", stat_errs, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
